alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Registered integer ALU for the 8-bit CPU datapath.
- Takes two operand buses and an operation code, and computes result and status flags.
- Both are captured in output registers on each rising clock edge.
- The stored carry flag feeds carry-chained ops (ADC/SBC), enabling multi-byte arithmetic.

Parameters:
- DATA_BUS_WIDTH, 8, operand/result width in bits (legal ≥ 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- op  input  alu_op_e (4)  operation select.
- register1  input  DATA_BUS_WIDTH  operand A.
- register2  input  DATA_BUS_WIDTH  operand B.
- result  output  DATA_BUS_WIDTH  registered result.
- flag  output  alu_flag_t (4)  registered flags {carry, zero, negative, overflow}, MSB..LSB.

Behaviour:
- Reset: rst high immediately forces result=0 and flag=0, independent of clk. Asserting reset mid-stream discards any pending computation.
- Latency: one cycle. Inputs sampled at edge N appear on result/flag after edge N; there is no hold or enable, so registers update every cycle.
- W = DATA_BUS_WIDTH. Cin = current flag.carry (registered value).
- Op encodings and results:
  - 0 ADD: A+B.
  - 1 ADC: A+B+Cin.
  - 2 SUB: A-B.
  - 3 SBC: A-B-Cin.
  - 4 AND, 5 OR, 6 XOR: bitwise.
  - 7 NOT: ~A.
  - 8 SHL: A<<1, LSB 0.
  - 9 SHR: logical A>>1, MSB 0.
  - 10 ROL: {A[W-2:0],A[W-1]}.
  - 11 ROR: {A[0],A[W-1:1]}.
  - 12 INC: A+1.
  - 13 DEC: A-1.
  - 14 CMP: flags from A-B; result holds its previous value.
  - 15 MUL: see Optional Feature.
- All arithmetic is unsigned modulo 2^W (wrap-around).
- Carry:
  - Add ops (ADD/ADC/INC): carry out of bit W-1.
  - Sub ops (SUB/SBC/DEC/CMP): borrow, =1 when the unsigned minuend < subtrahend (+Cin for SBC).
  - SHL/ROL: old A[W-1]. SHR/ROR: old A[0].
  - AND/OR/XOR/NOT: cleared.
- Zero: set when the computed value is all zeros. For CMP this is the A-B difference, so A==B gives zero=1.
- Negative: bit W-1 of the computed value.
- Overflow:
  - Add ops: signed overflow, i.e. operand signs equal and result sign differs.
  - Sub ops: operand signs differ and result sign differs from A.
  - All others: cleared.
- Boundary cases:
  - ADD 0xFF+0x01 → 0x00 with C=1, Z=1.
  - DEC 0x00 → 0xFF with C=1, N=1.
  - INC 0x7F → 0x80 with V=1.
- ADC/SBC use the flag value registered by the previous operation; a reset in between makes Cin=0.
- Undefined/unknown op: not possible with the 4-bit full encoding. The default branch yields result=0, flags=0.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: MUL returns the low W bits of A*B (unsigned). carry=1 when the high W bits are nonzero; zero/negative from the low W bits; overflow=0.
- Undefined: MUL behaves as a no-op. result and flag hold their previous values, and no multiplier logic is synthesized.

Decomposition:
- Package controlpack holds:
  - alu_op_e: 4-bit enum, names ALU_ADD…ALU_MUL, values as listed.
  - alu_flag_t: packed struct {carry, zero, negative, overflow}.
- A single combinational sub-module, alu_comb (op, A, B, Cin → next result, next flags, hold), is natural. alu_core wraps it with the async-reset output register.

Test Plan (W=8):
- Reset: assert rst between clock edges → result=0x00, flag=0000 immediately; hold rst over edges with ADD 5+3 applied → stays 0.
- ADD 0xFF+0x01 → result 0x00, C=1 Z=1 N=0 V=0 after one edge. Next cycle ADC 0x00+0x00 → 0x01, C=0.
- SUB 0x05-0x07 → 0xFE, C=1 N=1. SUB 0x80-0x01 → 0x7F, V=1. CMP 0x42,0x42 → Z=1, C=0, result unchanged from the prior value.
- Logic/shift:
  - AND 0xF0,0x3C → 0x30, C=0.
  - XOR 0xAA,0xAA → 0x00, Z=1.
  - SHL 0x81 → 0x02, C=1.
  - ROR 0x01 → 0x80, C=1, N=1.
- INC 0x7F → 0x80 V=1 N=1. DEC 0x00 → 0xFF C=1.
- MUL with ALU_MUL_EN: 0x10*0x10 → 0x00, C=1, Z=1; 0x03*0x05 → 0x0F, C=0. Without the macro: result/flag hold their previous values.

Source files
------------

// File: rtl/alu_core_pkg.sv
// Shared ALU types: operation encoding and the packed status-flag word.
// The ALU_MUL_EN build macro decides whether ALU_MUL does anything (see alu_comb).
package controlpack;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_ADC = 4'd1,
    ALU_SUB = 4'd2,
    ALU_SBC = 4'd3,
    ALU_AND = 4'd4,
    ALU_OR  = 4'd5,
    ALU_XOR = 4'd6,
    ALU_NOT = 4'd7,
    ALU_SHL = 4'd8,
    ALU_SHR = 4'd9,
    ALU_ROL = 4'd10,
    ALU_ROR = 4'd11,
    ALU_INC = 4'd12,
    ALU_DEC = 4'd13,
    ALU_CMP = 4'd14,
    ALU_MUL = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } alu_flag_t;

endpackage

// File: rtl/alu_core_comb.sv
// Combinational ALU datapath: next result/flags plus hold requests for the output register.
// Build macro ALU_MUL_EN enables the multiplier; without it ALU_MUL holds result and flags.
module alu_comb
  import controlpack::*;
#(
  parameter int DATA_BUS_WIDTH = 8
) (
  input  alu_op_e                   op,
  input  logic [DATA_BUS_WIDTH-1:0] a,
  input  logic [DATA_BUS_WIDTH-1:0] b,
  input  logic                      cin,
  output logic [DATA_BUS_WIDTH-1:0] nextResult,
  output alu_flag_t                 nextFlag,
  output logic                      holdResult,
  output logic                      holdFlag
);

  localparam int W = DATA_BUS_WIDTH;
  localparam logic [W-1:0] ONE = W'(1);

  logic [W:0]   wide;
  logic [W-1:0] res;
  logic         carry;
  logic         ovf;
  logic         valid;
`ifdef ALU_MUL_EN
  logic [2*W-1:0] product;
`endif

  function automatic logic addOvf(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [W-1:0] r);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  function automatic logic subOvf(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [W-1:0] r);
    return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Subtractions are done one bit wider so bit W is the borrow out.
  always_comb begin
    wide       = '0;
    res        = '0;
    carry      = 1'b0;
    ovf        = 1'b0;
    valid      = 1'b1;
    holdResult = 1'b0;
    holdFlag   = 1'b0;
`ifdef ALU_MUL_EN
    product    = '0;
`endif
    case (op)
      ALU_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        res   = wide[W-1:0];
        carry = wide[W];
        ovf   = addOvf(a, b, res);
      end
      ALU_ADC: begin
        wide  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        res   = wide[W-1:0];
        carry = wide[W];
        ovf   = addOvf(a, b, res);
      end
      ALU_SUB, ALU_CMP: begin
        wide       = {1'b0, a} - {1'b0, b};
        res        = wide[W-1:0];
        carry      = wide[W];
        ovf        = subOvf(a, b, res);
        holdResult = (op == ALU_CMP);
      end
      ALU_SBC: begin
        wide  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
        res   = wide[W-1:0];
        carry = wide[W];
        ovf   = subOvf(a, b, res);
      end
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      ALU_NOT: res = ~a;
      ALU_SHL: begin
        res   = {a[W-2:0], 1'b0};
        carry = a[W-1];
      end
      ALU_SHR: begin
        res   = {1'b0, a[W-1:1]};
        carry = a[0];
      end
      ALU_ROL: begin
        res   = {a[W-2:0], a[W-1]};
        carry = a[W-1];
      end
      ALU_ROR: begin
        res   = {a[0], a[W-1:1]};
        carry = a[0];
      end
      ALU_INC: begin
        wide  = {1'b0, a} + {1'b0, ONE};
        res   = wide[W-1:0];
        carry = wide[W];
        ovf   = addOvf(a, ONE, res);
      end
      ALU_DEC: begin
        wide  = {1'b0, a} - {1'b0, ONE};
        res   = wide[W-1:0];
        carry = wide[W];
        ovf   = subOvf(a, ONE, res);
      end
      ALU_MUL: begin
`ifdef ALU_MUL_EN
        product = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        res     = product[W-1:0];
        carry   = |product[2*W-1:W];
`else
        holdResult = 1'b1;
        holdFlag   = 1'b1;
`endif
      end
      default: valid = 1'b0;
    endcase

    nextResult        = valid ? res : '0;
    nextFlag.carry    = valid & carry;
    nextFlag.zero     = valid & (res == '0);
    nextFlag.negative = valid & res[W-1];
    nextFlag.overflow = valid & ovf;
  end

endmodule

// File: rtl/alu_core.sv
// Registered 8-bit (parameterisable) ALU; the stored carry feeds ADC/SBC for multi-byte math.
// Build macro ALU_MUL_EN enables ALU_MUL; otherwise MUL is a no-op.
module alu_core
  import controlpack::*;
#(
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  alu_op_e                   op,
  input  logic [DATA_BUS_WIDTH-1:0] register1,
  input  logic [DATA_BUS_WIDTH-1:0] register2,
  output logic [DATA_BUS_WIDTH-1:0] result,
  output alu_flag_t                 flag
);

  logic [DATA_BUS_WIDTH-1:0] nextResult;
  alu_flag_t                 nextFlag;
  logic                      holdResult;
  logic                      holdFlag;

  alu_comb #(
    .DATA_BUS_WIDTH(DATA_BUS_WIDTH)
  ) u_comb (
    .op        (op),
    .a         (register1),
    .b         (register2),
    .cin       (flag.carry),
    .nextResult(nextResult),
    .nextFlag  (nextFlag),
    .holdResult(holdResult),
    .holdFlag  (holdFlag)
  );

  // CMP keeps the old result and a disabled MUL keeps both registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      flag   <= '0;
    end else begin
      if (!holdResult) result <= nextResult;
      if (!holdFlag)   flag   <= nextFlag;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed boundary cases, multi-byte chains and
// randomized ops against an integer reference model. Honours ALU_MUL_EN like the RTL.
module tb_alu_core;
  import controlpack::*;

  logic      clk = 1'b0;
  logic      rst;
  alu_op_e   op;
  logic [7:0] register1;
  logic [7:0] register2;
  logic [7:0] result;
  alu_flag_t flag;

  int vectors     = 0;
  int miscompares = 0;

  int mRes, mC, mZ, mN, mV;

  typedef struct {
    alu_op_e    o;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;
    string      name;
  } row_t;

  always #5 clk = ~clk;

  alu_core #(.DATA_BUS_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .register1(register1),
    .register2(register2),
    .result   (result),
    .flag     (flag)
  );

  function automatic int toSigned(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  function automatic logic [3:0] modelFlag();
    return {mC[0], mZ[0], mN[0], mV[0]};
  endfunction

  task automatic modelReset();
    mRes = 0; mC = 0; mZ = 0; mN = 0; mV = 0;
  endtask

  // Reference model: plain integer arithmetic with signed range checks for overflow.
  task automatic modelStep(input int o, input int a, input int b);
    int s, sv, r, c, v;
    bit holdR, holdF;
    r = 0; c = 0; v = 0; holdR = 0; holdF = 0;
    case (o)
      0:  begin s = a + b;       r = s % 256; c = int'(s > 255); sv = toSigned(a) + toSigned(b);      v = int'(sv > 127 || sv < -128); end
      1:  begin s = a + b + mC;  r = s % 256; c = int'(s > 255); sv = toSigned(a) + toSigned(b) + mC; v = int'(sv > 127 || sv < -128); end
      2, 14: begin s = a - b;    r = (s + 512) % 256; c = int'(s < 0); sv = toSigned(a) - toSigned(b);      v = int'(sv > 127 || sv < -128); holdR = (o == 14); end
      3:  begin s = a - b - mC;  r = (s + 512) % 256; c = int'(s < 0); sv = toSigned(a) - toSigned(b) - mC; v = int'(sv > 127 || sv < -128); end
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = 255 - a;
      8:  begin r = (a * 2) % 256;           c = a / 128; end
      9:  begin r = a / 2;                   c = a % 2;   end
      10: begin r = (a * 2) % 256 + a / 128; c = a / 128; end
      11: begin r = a / 2 + (a % 2) * 128;   c = a % 2;   end
      12: begin s = a + 1; r = s % 256;         c = int'(s > 255); v = int'(toSigned(a) + 1 > 127); end
      13: begin s = a - 1; r = (s + 256) % 256; c = int'(s < 0);   v = int'(toSigned(a) - 1 < -128); end
      default: begin
`ifdef ALU_MUL_EN
        s = a * b; r = s % 256; c = int'(s > 255);
`else
        holdR = 1; holdF = 1;
`endif
      end
    endcase
    if (!holdF) begin
      mC = c; mZ = int'(r == 0); mN = int'(r >= 128); mV = v;
    end
    if (!holdR) mRes = r;
  endtask

  task automatic applyStimulus(input alu_op_e o, input logic [7:0] a, input logic [7:0] b);
    op = o; register1 = a; register2 = b;
    @(posedge clk);
    #1;
    modelStep(int'(o), int'(a), int'(b));
  endtask

  task automatic test_reset();
    rst = 1'b1; op = ALU_ADD; register1 = 8'h00; register2 = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
    applyStimulus(ALU_ADD, 8'h10, 8'h20);
    vectors++;
    if (result !== 8'h30) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_add: result=%h expected=30", result);
    end
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (result !== 8'h00 || flag !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL async_reset: result=%h flag=%b expected 00/0000", result, flag);
    end
    op = ALU_ADD; register1 = 8'h05; register2 = 8'h03;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (result !== 8'h00 || flag !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL reset_hold_%0d: result=%h flag=%b expected 00/0000", i, result, flag);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic test_directed();
    row_t rows[16];
    int n;
    rows[0]  = '{ALU_ADD, 8'hFF, 8'h01, 8'h00, 4'b1100, "add_ff_01"};
    rows[1]  = '{ALU_ADC, 8'h00, 8'h00, 8'h01, 4'b0000, "adc_carry_in"};
    rows[2]  = '{ALU_SUB, 8'h05, 8'h07, 8'hFE, 4'b1010, "sub_borrow"};
    rows[3]  = '{ALU_SUB, 8'h80, 8'h01, 8'h7F, 4'b0001, "sub_overflow"};
    rows[4]  = '{ALU_CMP, 8'h42, 8'h42, 8'h7F, 4'b0100, "cmp_equal"};
    rows[5]  = '{ALU_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, "and"};
    rows[6]  = '{ALU_XOR, 8'hAA, 8'hAA, 8'h00, 4'b0100, "xor_zero"};
    rows[7]  = '{ALU_SHL, 8'h81, 8'h00, 8'h02, 4'b1000, "shl_carry"};
    rows[8]  = '{ALU_ROR, 8'h01, 8'h00, 8'h80, 4'b1010, "ror_wrap"};
    rows[9]  = '{ALU_INC, 8'h7F, 8'h00, 8'h80, 4'b0011, "inc_overflow"};
    rows[10] = '{ALU_DEC, 8'h00, 8'h00, 8'hFF, 4'b1010, "dec_wrap"};
    rows[11] = '{ALU_SBC, 8'h10, 8'h05, 8'h0A, 4'b0000, "sbc_borrow_in"};
`ifdef ALU_MUL_EN
    rows[12] = '{ALU_MUL, 8'h10, 8'h10, 8'h00, 4'b1100, "mul_high"};
    rows[13] = '{ALU_MUL, 8'h03, 8'h05, 8'h0F, 4'b0000, "mul_low"};
`else
    rows[12] = '{ALU_MUL, 8'h12, 8'h34, 8'h0A, 4'b0000, "mul_hold_a"};
    rows[13] = '{ALU_MUL, 8'hFF, 8'hFF, 8'h0A, 4'b0000, "mul_hold_b"};
`endif
    n = 14;
    for (int i = 0; i < n; i++) begin
      applyStimulus(rows[i].o, rows[i].a, rows[i].b);
      vectors++;
      if (result !== rows[i].r || flag !== rows[i].f) begin
        miscompares++;
        $display("[TB] FAIL %s: result=%h flag=%b expected %h/%b",
                 rows[i].name, result, flag, rows[i].r, rows[i].f);
      end
    end
  endtask

  // 16-bit add and subtract built from ADD/ADC and SUB/SBC pairs.
  task automatic test_back_to_back();
    int x, y, exp;
    logic [7:0] lo;
    for (int i = 0; i < 40; i++) begin
      x = int'($urandom_range(0, 65535));
      y = int'($urandom_range(0, 65535));
      if (i < 20) begin
        applyStimulus(ALU_ADD, x[7:0], y[7:0]);
        lo = result;
        applyStimulus(ALU_ADC, x[15:8], y[15:8]);
        exp = x + y;
        vectors++;
        if ({result, lo} !== exp[15:0] || flag.carry !== exp[16]) begin
          miscompares++;
          $display("[TB] FAIL add16 %h+%h: got %h c=%b expected %h c=%b",
                   x[15:0], y[15:0], {result, lo}, flag.carry, exp[15:0], exp[16]);
        end
      end else begin
        applyStimulus(ALU_SUB, x[7:0], y[7:0]);
        lo = result;
        applyStimulus(ALU_SBC, x[15:8], y[15:8]);
        exp = (x - y + 65536) % 65536;
        vectors++;
        if ({result, lo} !== exp[15:0] || flag.carry !== (x < y)) begin
          miscompares++;
          $display("[TB] FAIL sub16 %h-%h: got %h c=%b expected %h c=%b",
                   x[15:0], y[15:0], {result, lo}, flag.carry, exp[15:0], (x < y));
        end
      end
    end
  endtask

  task automatic test_random();
    alu_op_e o;
    logic [7:0] a, b;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (result !== 8'h00 || flag !== 4'b0000) begin
          miscompares++;
          $display("[TB] FAIL random_reset_%0d: result=%h flag=%b expected 00/0000", i, result, flag);
        end
        @(negedge clk);
        rst = 1'b0;
        modelReset();
      end else begin
        o = alu_op_e'($urandom_range(0, 15));
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        applyStimulus(o, a, b);
        vectors++;
        if (result !== mRes[7:0] || flag !== modelFlag()) begin
          miscompares++;
          $display("[TB] FAIL random_%0d %s a=%h b=%h: result=%h flag=%b expected %h/%b",
                   i, o.name(), a, b, result, flag, mRes[7:0], modelFlag());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
